// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with HI/LO registers
//
// Accepts mult/multu/div/divu from the E stage, holds busy for a fixed
// latency, then commits the 64-bit result to HI/LO. Also handles
// mthi/mtlo writes, mfhi/mflo reads, and D-stage stall requests.
// Optional macro MDU_MADD_EN adds madd/maddu ({HI,LO} += rs*rt).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   instr_d               D-stage instruction (stall detection only)
//   instr_e, valid_e      E-stage instruction and its valid flag
//   rs_val, rt_val        forwarded E-stage operands
//   start                 MDU operation accepted this cycle (combinational)
//   busy                  multi-cycle operation in progress
//   stall_req             D-stage MDU instruction must wait
//   hilo_rdata            HI for mfhi, LO for mflo, else 0
//   hi, lo                architectural HI/LO
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic        valid_e,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [7:0] MLAT = 8'(MULT_LAT);
  localparam logic [7:0] DLAT = 8'(DIV_LAT);

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [63:0] shadow;
  logic        commit;   // low when the running op was a divide by zero

  // Any of the MDU encodings; used for the D-stage stall check.
  function automatic logic is_md(input logic [31:0] instr);
    logic md;
    md = (instr[31:26] == OP_SPECIAL) &&
         (instr[5:0] inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                             FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
`ifdef MDU_MADD_EN
    md = md || ((instr[31:26] == OP_SPECIAL2) &&
                (instr[5:0] == 6'b000000 || instr[5:0] == 6'b000001));
`endif
    return md;
  endfunction

  // Only opcode and funct fields participate in decode.
  logic unused_bits;
  assign unused_bits = ^{instr_d[25:6], instr_e[25:6]};

  logic special_e;
  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_madd, is_maddu;

  assign special_e = (instr_e[31:26] == OP_SPECIAL);
  assign is_mult   = special_e && (instr_e[5:0] == FN_MULT);
  assign is_multu  = special_e && (instr_e[5:0] == FN_MULTU);
  assign is_div    = special_e && (instr_e[5:0] == FN_DIV);
  assign is_divu   = special_e && (instr_e[5:0] == FN_DIVU);
  assign is_mfhi   = special_e && (instr_e[5:0] == FN_MFHI);
  assign is_mthi   = special_e && (instr_e[5:0] == FN_MTHI);
  assign is_mflo   = special_e && (instr_e[5:0] == FN_MFLO);
  assign is_mtlo   = special_e && (instr_e[5:0] == FN_MTLO);
`ifdef MDU_MADD_EN
  assign is_madd   = (instr_e[31:26] == OP_SPECIAL2) && (instr_e[5:0] == 6'b000000);
  assign is_maddu  = (instr_e[31:26] == OP_SPECIAL2) && (instr_e[5:0] == 6'b000001);
`else
  assign is_madd   = 1'b0;
  assign is_maddu  = 1'b0;
`endif

  logic is_mul_any, is_div_any;
  assign is_mul_any = is_mult | is_multu | is_madd | is_maddu;
  assign is_div_any = is_div | is_divu;

  assign busy = (state == ST_BUSY);

  // Reset gates the combinational outputs so they drop without a clock edge.
  assign start     = ~reset & valid_e & (is_mul_any | is_div_any) & ~busy;
  assign stall_req = ~reset & is_md(instr_d) & (start | busy);

  assign hilo_rdata = is_mfhi ? hi : (is_mflo ? lo : 32'h0);

  // Result datapath. Multiplies use sign/zero-extended 64-bit operands so
  // the low 64 product bits are correct for both flavours. Division runs on
  // magnitudes so 0x80000000 / -1 needs no special case: the magnitude
  // quotient 0x80000000 negates back to itself and the remainder is 0.
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [63:0] result;
  logic        div_zero;
  logic [7:0]  op_lat;

  always_comb begin
    mul_a  = (is_mult | is_madd) ? {{32{rs_val[31]}}, rs_val} : {32'h0, rs_val};
    mul_b  = (is_mult | is_madd) ? {{32{rt_val[31]}}, rt_val} : {32'h0, rt_val};
    prod   = mul_a * mul_b;

    a_neg  = is_div & rs_val[31];
    b_neg  = is_div & rt_val[31];
    a_mag  = a_neg ? -rs_val : rs_val;
    b_mag  = b_neg ? -rt_val : rt_val;
    b_safe = (b_mag == 32'h0) ? 32'h1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    result = 64'h0;
    if (is_mult | is_multu)
      result = prod;
    else if (is_madd | is_maddu)
      result = {hi, lo} + prod;
    else if (is_div_any)
      result = {rem, quot};

    div_zero = is_div_any & (rt_val == 32'h0);
    op_lat   = is_div_any ? DLAT : MLAT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 8'h0;
      shadow <= 64'h0;
      commit <= 1'b0;
      hi     <= 32'h0;
      lo     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shadow <= result;
            commit <= ~div_zero;
            cnt    <= op_lat;
            state  <= ST_BUSY;
          end else if (valid_e && is_mthi) begin
            hi <= rs_val;
          end else if (valid_e && is_mtlo) begin
            lo <= rs_val;
          end
        end
        ST_BUSY: begin
          // New starts and mthi/mtlo are ignored here.
          cnt <= cnt - 8'h1;
          if (cnt == 8'h1) begin
            state <= ST_IDLE;
            if (commit) begin
              hi <= shadow[63:32];
              lo <= shadow[31:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a behavioural model
module tb_mdu_ctrl;

  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, instr_e, rs_val, rt_val;
  logic        valid_e;
  logic        start, busy, stall_req;
  logic [31:0] hilo_rdata, hi, lo;

  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .instr_e(instr_e),
    .valid_e(valid_e), .rs_val(rs_val), .rt_val(rt_val), .start(start),
    .busy(busy), .stall_req(stall_req), .hilo_rdata(hilo_rdata),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural HI/LO plus a pending result that lands
  // a fixed number of cycles after acceptance.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  bit          m_commit;
  int          m_left;

  // 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mthi, 7 mflo, 8 mtlo, 9 madd, 10 maddu
  function automatic int kind(input logic [31:0] i);
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        F_MULT:  return 1;
        F_MULTU: return 2;
        F_DIV:   return 3;
        F_DIVU:  return 4;
        F_MFHI:  return 5;
        F_MTHI:  return 6;
        F_MFLO:  return 7;
        F_MTLO:  return 8;
        default: return 0;
      endcase
    end
`ifdef MDU_MADD_EN
    if (i[31:26] == 6'h1C && i[5:0] == 6'h00) return 9;
    if (i[31:26] == 6'h1C && i[5:0] == 6'h01) return 10;
`endif
    return 0;
  endfunction

  function automatic bit is_arith(input int k);
    return (k >= 1 && k <= 4) || k == 9 || k == 10;
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {op, mid, fn};
  endfunction

  function automatic bit exp_start();
    return valid_e && is_arith(kind(instr_e)) && (m_left == 0);
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    int k;
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    k = kind(instr_e);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_commit) {m_hi, m_lo} = m_pend;
    end else if (exp_start()) begin
      sa = longint'(int'(rs_val));
      sb = longint'(int'(rt_val));
      ua = {32'h0, rs_val};
      ub = {32'h0, rt_val};
      m_commit = 1;
      m_left   = (k == 3 || k == 4) ? DL : ML;
      case (k)
        1: m_pend = 64'(sa * sb);
        2: m_pend = ua * ub;
        3: if (rt_val == 0) m_commit = 0;
           else begin
             q = sa / sb;
             r = sa % sb;
             m_pend = {r[31:0], q[31:0]};
           end
        4: if (rt_val == 0) m_commit = 0;
           else m_pend = {rs_val % rt_val, rs_val / rt_val};
        9: m_pend = {m_hi, m_lo} + 64'(sa * sb);
        10: m_pend = {m_hi, m_lo} + ua * ub;
        default: m_pend = 64'h0;
      endcase
    end else if (valid_e && k == 6) begin
      m_hi = rs_val;
    end else if (valid_e && k == 8) begin
      m_lo = rs_val;
    end
  endtask

  bit chk_en = 0;
  int busy_seen, stall_seen;

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_start, e_busy, e_stall;
      logic [31:0] e_rd;
      e_start = exp_start();
      e_busy  = (m_left > 0);
      e_stall = (kind(instr_d) != 0) && (e_start || e_busy);
      e_rd    = (kind(instr_e) == 5) ? m_hi : (kind(instr_e) == 7) ? m_lo : 32'h0;
      chk("start", start, e_start);
      chk("busy", busy, e_busy);
      chk("stall_req", stall_req, e_stall);
      chk("hilo_rdata", hilo_rdata, e_rd);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (busy) busy_seen++;
      if (stall_req) stall_seen++;
    end
  end

  task automatic step(input logic v, input logic [31:0] ie, input logic [31:0] id,
                      input logic [31:0] a, input logic [31:0] b);
    valid_e = v; instr_e = ie; instr_d = id; rs_val = a; rt_val = b;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Issue one arithmetic op and idle until busy drops (bounded).
  task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] id);
    int i;
    busy_seen = 0;
    stall_seen = 0;
    step(1'b1, enc(op, fn), id, a, b);
    i = 0;
    while (busy && i < 300) begin
      step(1'b0, 32'h0, id, 32'h0, 32'h0);
      i++;
    end
    if (i >= 300) chk("busy_timeout", 32'(i), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 15))
      0: return enc(6'h00, F_MULT);
      1: return enc(6'h00, F_MULTU);
      2: return enc(6'h00, F_DIV);
      3: return enc(6'h00, F_DIVU);
      4: return enc(6'h00, F_MFHI);
      5: return enc(6'h00, F_MTHI);
      6: return enc(6'h00, F_MFLO);
      7: return enc(6'h00, F_MTLO);
      8: return enc(6'h1C, 6'h00);
      9: return enc(6'h1C, 6'h01);
      10: return enc(6'h00, 6'h20);
      11: return enc(6'h23, F_MULT);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] save_hi, save_lo;
    int n_starts;
    reset = 1'b1;
    valid_e = 1'b1;
    instr_e = enc(6'h00, F_MULT);
    instr_d = enc(6'h00, F_MFLO);
    rs_val = 32'd3;
    rt_val = 32'd4;
    m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0; m_commit = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", start, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_en = 1;

    // First op straight out of reset, mult -2 * 3.
    run_op(6'h00, F_MULT, 32'hFFFF_FFFE, 32'd3, 32'h0);
    chk("mult_busy_len", 32'(busy_seen), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // divu 100/7 with mflo waiting in D.
    run_op(6'h00, F_DIVU, 32'd100, 32'd7, enc(6'h00, F_MFLO));
    chk("divu_stall_len", 32'(stall_seen), 32'd11);
    chk("divu_busy_len", 32'(busy_seen), 32'd10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(6'h00, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    run_op(6'h00, F_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    save_hi = hi;
    save_lo = lo;
    run_op(6'h00, F_DIV, 32'd55, 32'h0, 32'h0);
    chk("div0_busy_len", 32'(busy_seen), 32'd10);
    chk("div0_hi", hi, save_hi);
    chk("div0_lo", lo, save_lo);

    // mthi then mfhi; mthi while busy must be ignored.
    step(1'b1, enc(6'h00, F_MTHI), 32'h0, 32'h1234, 32'h0);
    valid_e = 1'b1;
    instr_e = enc(6'h00, F_MFHI);
    #1;
    chk("mfhi_rd", hilo_rdata, 32'h1234);
    step(1'b1, enc(6'h00, F_MFHI), 32'h0, 32'h0, 32'h0);
    step(1'b1, enc(6'h00, F_MULT), 32'h0, 32'd2, 32'd3);
    step(1'b1, enc(6'h00, F_MTHI), 32'h0, 32'hDEAD, 32'h0);
    chk("mthi_busy_hi", hi, 32'h1234);
    run_op(6'h00, 6'h20, 32'h0, 32'h0, 32'h0);
    chk("mult23_lo", lo, 32'd6);

    // madd encoding with HI:LO = 0:5.
    step(1'b1, enc(6'h00, F_MTHI), 32'h0, 32'h0, 32'h0);
    step(1'b1, enc(6'h00, F_MTLO), 32'h0, 32'd5, 32'h0);
    run_op(6'h1C, 6'h00, 32'd2, 32'd3, 32'h0);
`ifdef MDU_MADD_EN
    chk("madd_lo", lo, 32'd11);
    chk("madd_busy_len", 32'(busy_seen), 32'd5);
`else
    chk("madd_off_lo", lo, 32'd5);
    chk("madd_off_busy", 32'(busy_seen), 32'd0);
`endif

    // Asynchronous reset three cycles into a divide.
    step(1'b1, enc(6'h00, F_MTHI), 32'h0, 32'hAAAA, 32'h0);
    step(1'b1, enc(6'h00, F_DIV), 32'h0, 32'd50, 32'd3);
    repeat (3) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("pre_rst_busy", busy, 1'b1);
    chk_en = 0;
    valid_e = 1'b1;
    instr_e = enc(6'h00, F_DIV);
    instr_d = enc(6'h00, F_MFLO);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_start", start, 1'b0);
    chk("arst_stall", stall_req, 1'b0);
    m_hi = 0; m_lo = 0; m_left = 0; m_commit = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_en = 1;
    run_op(6'h00, F_MULTU, 32'd7, 32'd6, 32'h0);
    chk("post_rst_busy_len", 32'(busy_seen), 32'd5);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);

    // Randomized traffic, including starts presented while busy.
    n_starts = 0;
    for (int c = 0; c < 4000; c++) begin
      logic v;
      v = ($urandom_range(0, 9) < 8);
      if (v && is_arith(kind(instr_e)) && m_left == 0) n_starts++;
      step(v, rand_instr(), rand_instr(), rand_operand(), rand_operand());
    end
    if (n_starts == 0) chk("rand_no_starts", 32'(n_starts), 32'd1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for mult/multu; legal range 1..255.
REQ-002 Parameter DIV_LAT, default 10, busy cycles for div/divu; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr_d  input  32  D-stage instruction, used only for stall detection.
REQ-006 instr_e  input  32  E-stage instruction, decoded for MDU operations.
REQ-007 valid_e  input  1  E-stage instruction valid (low when bubble or flushed).
REQ-008 rs_val  input  32  forwarded rs operand in E.
REQ-009 rt_val  input  32  forwarded rt operand in E.
REQ-010 start  output  1  MDU operation accepted this cycle.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 stall_req  output  1  D-stage MDU instruction must stall.
REQ-013 hilo_rdata  output  32  HI for mfhi, LO for mflo, else 0.
REQ-014 hi  output  32  architectural HI.
REQ-015 lo  output  32  architectural LO.

Function
REQ-016 Decode: opcode 000000 with funct mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011; "md" = any of these eight.
REQ-017 start = valid_e & (mult|multu|div|divu) & ~busy, combinational.
REQ-018 On start edge: compute 64-bit result from rs_val/rt_val into shadow register; load counter with MULT_LAT or DIV_LAT; busy=1 from next cycle.
REQ-019 Counter decrements each cycle while busy; on edge where counter goes 1->0, write shadow to HI/LO and clear busy; busy is high exactly LAT cycles.
REQ-020 mult: {HI,LO}=signed 64-bit product; multu unsigned.
REQ-021 div: LO=signed quotient truncated toward zero, HI=remainder with dividend's sign; divu unsigned.
REQ-022 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 Divisor zero: busy sequence runs normally; HI/LO unchanged at completion.
REQ-024 mthi/mtlo: write rs_val to HI/LO on edge when valid_e & ~busy; ignored while busy.
REQ-025 hilo_rdata combinational from current HI/LO; result-write and read in same cycle returns old value.
REQ-026 stall_req = md(instr_d) & (start | busy).
REQ-027 Start while busy is impossible by REQ-026; if presented, ignored, running operation unaffected.
REQ-028 valid_e low: no start, no mthi/mtlo write.

Reset
REQ-029 reset high forces busy=0, counter=0, shadow=0, HI=0, LO=0, start and stall_req deassert immediately; in-flight result discarded.
REQ-030 After reset release, first valid MDU instruction is accepted with no extra delay.

Configuration
REQ-031 Macro MDU_MADD_EN: when defined, decode opcode 011100 funct 000000 (madd) and 000001 (maddu), latency MULT_LAT, {HI,LO} += signed/unsigned rs*rt (mod 2^64), included in start and md; when undefined, these encodings are not MDU instructions.

Verification
REQ-032 mult rs=0xFFFFFFFE, rt=3 -> start 1 cycle, busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 divu rs=100, rt=7 with mflo in D during busy -> stall_req high 11 cycles (start+10 busy), then LO=14, HI=2.
REQ-034 div rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0; div rt=0 -> HI/LO unchanged.
REQ-035 reset asserted at busy cycle 3 of div -> busy, HI, LO become 0 without clock edge; next mult completes normally.
REQ-036 mthi rs=0x1234 then mfhi -> hilo_rdata=0x1234; mthi while busy -> HI unchanged.
REQ-037 With MDU_MADD_EN, HI:LO=0:5, madd rs=2, rt=3 -> LO=11; without it, same encoding -> no start, HI/LO unchanged.
